regfile_writeback: RTL and testbench

//  Write-side master for the 32x32 register file: drives waddr/wdata/wren.

---
 rtl/regfile_writeback.sv | 127 ++++++++++++
 tb/tb_regfile_writeback.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// regfile_writeback: single write-port master for the 32x32 register file.
// Single-cycle ALU results take the port with strict priority; long-latency
// results queue in a small FIFO and drain when the ALU leaves the port idle.
// A scoreboard marks destinations with long-latency writes still outstanding.
// Optional feature macro: REGFILE_WB_FWD_EN adds two combinational forwarding
// taps on the registered write port.
module regfile_writeback #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_valid,
  input  logic [AW-1:0]        alu_rd,
  input  logic [DW-1:0]        alu_data,
  input  logic                 lu_valid,
  output logic                 lu_ready,
  input  logic [AW-1:0]        lu_rd,
  input  logic [DW-1:0]        lu_data,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_rd,
  output logic                 issue_stall,
  output logic [(1<<AW)-1:0]   busy,
`ifdef REGFILE_WB_FWD_EN
  input  logic [AW-1:0]        fwd_raddr0,
  input  logic [AW-1:0]        fwd_raddr1,
  output logic                 fwd_hit0,
  output logic                 fwd_hit1,
  output logic [DW-1:0]        fwd_data0,
  output logic [DW-1:0]        fwd_data1,
`endif
  output logic                 wren,
  output logic [AW-1:0]        waddr,
  output logic [DW-1:0]        wdata
);

  localparam int NREG = 1 << AW;
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;

  logic [AW-1:0]   q_rd   [DEPTH];
  logic [DW-1:0]   q_data [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            alu_wr;
  logic            push;
  logic            pop;
  logic            issue_set;
  logic [NREG-1:0] busy_next;

  // Port arbitration: ALU first, FIFO head only when the ALU leaves the port free.
  // rd==0 long-latency results complete the handshake but are never queued.
  assign alu_wr    = alu_valid && (alu_rd != '0);
  assign pop       = !alu_wr && (count != '0);
  assign lu_ready  = (count < CW'(DEPTH));
  assign push      = lu_valid && lu_ready && (lu_rd != '0);
  assign issue_set = issue_valid && (issue_rd != '0) && !busy[issue_rd];
  assign issue_stall = issue_valid && busy[issue_rd];

  // FIFO storage; contents are don't-care while empty, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= lu_rd;
      q_data[wr_ptr] <= lu_data;
    end
  end

  // FIFO pointers and occupancy; power-of-2 depth lets pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered write port; address/data hold their last values when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wren  <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else if (alu_wr) begin
      wren  <= 1'b1;
      waddr <= alu_rd;
      wdata <= alu_data;
    end else if (pop) begin
      wren  <= 1'b1;
      waddr <= q_rd[rd_ptr];
      wdata <= q_data[rd_ptr];
    end else begin
      wren  <= 1'b0;
    end
  end

  // Scoreboard next state: commit clears, then a new issue sets (set wins).
  always_comb begin
    busy_next = busy;
    if (pop)       busy_next[q_rd[rd_ptr]] = 1'b0;
    if (issue_set) busy_next[issue_rd]     = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

`ifdef REGFILE_WB_FWD_EN
  assign fwd_hit0  = wren && (waddr != '0) && (waddr == fwd_raddr0);
  assign fwd_hit1  = wren && (waddr != '0) && (waddr == fwd_raddr1);
  assign fwd_data0 = fwd_hit0 ? wdata : '0;
  assign fwd_data1 = fwd_hit1 ? wdata : '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios plus a randomized run,
// checked against a queue-based behavioural model of the write port.
module tb_regfile_writeback;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_stall;
  logic [31:0] busy;
  logic        wren;
  logic [4:0]  waddr;
  logic [31:0] wdata;
`ifdef REGFILE_WB_FWD_EN
  logic [4:0]  fwd_raddr0;
  logic [4:0]  fwd_raddr1;
  logic        fwd_hit0;
  logic        fwd_hit1;
  logic [31:0] fwd_data0;
  logic [31:0] fwd_data1;
`endif

  int checks = 0;
  int errors = 0;

  regfile_writeback #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_stall(issue_stall),
    .busy(busy),
`ifdef REGFILE_WB_FWD_EN
    .fwd_raddr0(fwd_raddr0), .fwd_raddr1(fwd_raddr1),
    .fwd_hit0(fwd_hit0), .fwd_hit1(fwd_hit1),
    .fwd_data0(fwd_data0), .fwd_data1(fwd_data1),
`endif
    .wren(wren), .waddr(waddr), .wdata(wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending long-latency results as a queue, scoreboard as a bit set.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_busy;
  logic        m_wren;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  task automatic model_reset();
    m_q.delete();
    m_busy  = '0;
    m_wren  = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  task automatic model_edge();
    bit          room;
    logic [31:0] busy_before;
    ent_t        e;
    room        = (m_q.size() < DEPTH);
    busy_before = m_busy;
    if (alu_valid && alu_rd != 0) begin
      m_wren = 1'b1; m_waddr = alu_rd; m_wdata = alu_data;
    end else if (m_q.size() > 0) begin
      e = m_q.pop_front();
      m_wren = 1'b1; m_waddr = e.rd; m_wdata = e.data;
      m_busy[e.rd] = 1'b0;
    end else begin
      m_wren = 1'b0;
    end
    if (lu_valid && room && lu_rd != 0) begin
      e.rd = lu_rd; e.data = lu_data;
      m_q.push_back(e);
    end
    if (issue_valid && issue_rd != 0 && !busy_before[issue_rd]) m_busy[issue_rd] = 1'b1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0;
    issue_valid = 0; issue_rd = 0;
`ifdef REGFILE_WB_FWD_EN
    fwd_raddr0 = 0; fwd_raddr1 = 0;
`endif
  endtask

  // Advance one clock; the model sees the same inputs the DUT samples.
  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic drain(input int n);
    idle_inputs();
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    model_reset();
    #12;
    checks++; if (wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b want 0", wren); end
    checks++; if (waddr !== 5'd0 || wdata !== 32'd0) begin errors++; $display("FAIL reset_addr_data: got %h/%h want 0/0", waddr, wdata); end
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL reset_busy: got %h want 0", busy); end
    checks++; if (lu_ready !== 1'b1 || issue_stall !== 1'b0) begin errors++; $display("FAIL reset_ready_stall: got %b/%b want 1/0", lu_ready, issue_stall); end
    rst_n = 1;
    cycle();
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_rd = 5'd1; alu_data = $urandom;
      lu_valid = 1; lu_rd = 5'(11 + i); lu_data = $urandom;
      issue_valid = (i == 0); issue_rd = 5'd11;
      cycle();
    end
    idle_inputs();
    checks++; if (busy[11] !== 1'b1 || m_q.size() != 3) begin errors++; $display("FAIL midop_setup: busy11 %b queue %0d want 1/3", busy[11], m_q.size()); end
    #2;
    rst_n = 0;
    model_reset();
    #1;
    checks++; if (wren !== 1'b0 || busy !== 32'd0 || lu_ready !== 1'b1) begin errors++; $display("FAIL midop_reset: wren %b busy %h ready %b want 0/0/1", wren, busy, lu_ready); end
    cycle(); cycle();
    #3;
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++; if (wren !== 1'b0) begin errors++; $display("FAIL midop_stale_write: cycle %0d got wren %b addr %h want 0", i, wren, waddr); end
    end
  endtask

  task automatic test_alu();
    drain(6);
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    cycle();
    checks++; if (wren !== 1'b1 || waddr !== 5'd5 || wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_write: got %b/%h/%h want 1/05/deadbeef", wren, waddr, wdata); end
    alu_rd = 5'd0; alu_data = 32'h12345678;
    cycle();
    checks++; if (wren !== 1'b0 || waddr !== 5'd5 || wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_rd0: got %b/%h/%h want 0/05/deadbeef", wren, waddr, wdata); end
    idle_inputs();
  endtask

  task automatic test_contention();
    drain(6);
    issue_valid = 1; issue_rd = 5'd7;
    cycle();
    idle_inputs();
    checks++; if (busy[7] !== 1'b1) begin errors++; $display("FAIL cont_issue: busy7 got %b want 1", busy[7]); end
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'd1;
    lu_valid = 1; lu_rd = 5'd7; lu_data = 32'd2;
    cycle();
    idle_inputs();
    checks++; if (wren !== 1'b1 || waddr !== 5'd3 || wdata !== 32'd1 || busy[7] !== 1'b1) begin errors++; $display("FAIL cont_t1: got %b/%h/%h busy7 %b want 1/03/1 busy7 1", wren, waddr, wdata, busy[7]); end
    cycle();
    checks++; if (wren !== 1'b1 || waddr !== 5'd7 || wdata !== 32'd2 || busy[7] !== 1'b0) begin errors++; $display("FAIL cont_t2: got %b/%h/%h busy7 %b want 1/07/2 busy7 0", wren, waddr, wdata, busy[7]); end
  endtask

  task automatic test_full();
    drain(6);
    for (int i = 0; i < DEPTH; i++) begin
      alu_valid = 1; alu_rd = 5'(1 + i); alu_data = $urandom;
      lu_valid = 1; lu_rd = 5'(10 + i); lu_data = 32'h100 + i;
      #1;
      checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL full_ready_fill: push %0d got %b want 1", i, lu_ready); end
      cycle();
      checks++; if (wren !== 1'b1 || waddr !== 5'(1 + i)) begin errors++; $display("FAIL full_alu_prio: got %b/%h want 1/%h", wren, waddr, 5'(1 + i)); end
    end
    alu_valid = 0; lu_valid = 1; lu_rd = 5'd20; lu_data = 32'hBAD;
    #1;
    checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL full_ready_low: got %b want 0", lu_ready); end
    for (int i = 0; i < DEPTH; i++) begin
      cycle();
      lu_valid = 0;
      checks++; if (wren !== 1'b1 || waddr !== 5'(10 + i) || wdata !== 32'h100 + i) begin errors++; $display("FAIL full_drain: entry %0d got %b/%h/%h want 1/%h/%h", i, wren, waddr, wdata, 5'(10 + i), 32'h100 + i); end
      checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back: entry %0d got %b want 1", i, lu_ready); end
    end
    cycle();
    checks++; if (wren !== 1'b0) begin errors++; $display("FAIL full_refused_push: got wren %b addr %h want 0", wren, waddr); end
  endtask

  task automatic test_scoreboard();
    logic [31:0] saved;
    drain(6);
    issue_valid = 1; issue_rd = 5'd9;
    #1;
    checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL sb_first_stall: got %b want 0", issue_stall); end
    cycle();
    checks++; if (busy[9] !== 1'b1) begin errors++; $display("FAIL sb_set: busy9 got %b want 1", busy[9]); end
    saved = busy;
    checks++; if (issue_stall !== 1'b1) begin errors++; $display("FAIL sb_reissue_stall: got %b want 1", issue_stall); end
    cycle();
    checks++; if (busy !== saved) begin errors++; $display("FAIL sb_stall_nochange: got %h want %h", busy, saved); end
    idle_inputs();
    lu_valid = 1; lu_rd = 5'd9; lu_data = 32'h99;
    cycle();
    idle_inputs();
    cycle();
    checks++; if (wren !== 1'b1 || waddr !== 5'd9 || busy[9] !== 1'b0) begin errors++; $display("FAIL sb_commit_clear: got %b/%h busy9 %b want 1/09/0", wren, waddr, busy[9]); end
    lu_valid = 1; lu_rd = 5'd9; lu_data = 32'h98;
    cycle();
    idle_inputs();
    issue_valid = 1; issue_rd = 5'd9;
    cycle();
    idle_inputs();
    checks++; if (wren !== 1'b1 || waddr !== 5'd9 || busy[9] !== 1'b1) begin errors++; $display("FAIL sb_set_wins: got %b/%h busy9 %b want 1/09/1", wren, waddr, busy[9]); end
    saved = busy;
    issue_valid = 1; issue_rd = 5'd0;
    lu_valid = 1; lu_rd = 5'd0; lu_data = 32'h77;
    #1;
    checks++; if (issue_stall !== 1'b0 || lu_ready !== 1'b1) begin errors++; $display("FAIL sb_rd0_pre: stall %b ready %b want 0/1", issue_stall, lu_ready); end
    cycle();
    idle_inputs();
    cycle();
    checks++; if (wren !== 1'b0 || busy !== saved) begin errors++; $display("FAIL sb_rd0_drop: wren %b busy %h want 0/%h", wren, busy, saved); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      alu_valid   = ($urandom_range(0, 2) == 0);
      alu_rd      = 5'($urandom_range(0, 31));
      alu_data    = $urandom;
      lu_valid    = ($urandom_range(0, 1) == 0);
      lu_rd       = 5'($urandom_range(0, 31));
      lu_data     = $urandom;
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_rd    = 5'($urandom_range(0, 31));
`ifdef REGFILE_WB_FWD_EN
      fwd_raddr0  = 5'($urandom_range(0, 31));
      fwd_raddr1  = ($urandom_range(0, 1) == 0) ? m_waddr : 5'($urandom_range(0, 31));
`endif
      #1;
      checks++; if (lu_ready !== (m_q.size() < DEPTH)) begin errors++; $display("FAIL rand_ready: cycle %0d got %b want %b", n, lu_ready, m_q.size() < DEPTH); end
      checks++; if (issue_stall !== (issue_valid && m_busy[issue_rd])) begin errors++; $display("FAIL rand_stall: cycle %0d got %b want %b", n, issue_stall, issue_valid && m_busy[issue_rd]); end
      cycle();
      checks++; if (wren !== m_wren || waddr !== m_waddr || wdata !== m_wdata) begin errors++; $display("FAIL rand_write: cycle %0d got %b/%h/%h want %b/%h/%h", n, wren, waddr, wdata, m_wren, m_waddr, m_wdata); end
      checks++; if (busy !== m_busy) begin errors++; $display("FAIL rand_busy: cycle %0d got %h want %h", n, busy, m_busy); end
`ifdef REGFILE_WB_FWD_EN
      checks++; if (fwd_hit1 !== (m_wren && m_waddr != 0 && m_waddr == fwd_raddr1) || fwd_data1 !== (fwd_hit1 ? m_wdata : 32'd0)) begin errors++; $display("FAIL rand_fwd1: cycle %0d got %b/%h", n, fwd_hit1, fwd_data1); end
`endif
    end
    idle_inputs();
  endtask

`ifdef REGFILE_WB_FWD_EN
  task automatic test_fwd();
    drain(6);
    alu_valid = 1; alu_rd = 5'd4; alu_data = 32'hCAFE0004;
    cycle();
    idle_inputs();
    fwd_raddr0 = 5'd4; fwd_raddr1 = 5'd0;
    #1;
    checks++; if (fwd_hit0 !== 1'b1 || fwd_data0 !== 32'hCAFE0004) begin errors++; $display("FAIL fwd_hit0: got %b/%h want 1/cafe0004", fwd_hit0, fwd_data0); end
    checks++; if (fwd_hit1 !== 1'b0 || fwd_data1 !== 32'd0) begin errors++; $display("FAIL fwd_hit1: got %b/%h want 0/0", fwd_hit1, fwd_data1); end
    cycle();
    checks++; if (fwd_hit0 !== 1'b0 || fwd_data0 !== 32'd0) begin errors++; $display("FAIL fwd_idle: got %b/%h want 0/0", fwd_hit0, fwd_data0); end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_contention();
    test_full();
    test_scoreboard();
    test_reset_midop();
`ifdef REGFILE_WB_FWD_EN
    test_fwd();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
